sw_job_issuer: RTL
==================

SW_JOB_ISSUER -- requirements
Module: sw_job_issuer

Interface
REQ-001 SHALL have parameter DATA_W, default 512, width of sw_data_a/sw_data_b and of each input operand.
REQ-002 SHALL have parameter RES_W, default 256, width of the result.
REQ-003 SHALL have parameter CNT_W, default 16, width of the completed-job counter.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit (used only under SW_ISSUER_TIMEOUT_EN).
REQ-005 SHALL have these ports: clk in 1, clock; resetb in 1, reset, synchronous, active-low.
REQ-006 SHALL have these ports: in_valid in 1, job offered; in_ready out 1, job accepted when high with in_valid; in_data in DATA_W, data cache line; in_weight in DATA_W, weight cache line.
REQ-007 SHALL have these ports: out_valid out 1, result held; out_ready in 1, consumer accepts; out_result out RES_W, convolution result.
REQ-008 SHALL have these ports: sw_start out 1; sw_data_a out DATA_W; sw_data_b out DATA_W; sw_ready in 1; sw_max_out in RES_W. These are the initiator end of sw_bus.
REQ-009 SHALL have these ports: busy out 1, job in flight; jobs_done out CNT_W, count of captured results; error out 1, sticky watchdog flag.

Function
REQ-010 SHALL implement states IDLE, ISSUE, ACK, WAIT, DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE.
REQ-012 IDLE: on in_valid, SHALL latch in_data into sw_data_a and in_weight into sw_data_b, then go to ISSUE.
REQ-013 ISSUE: SHALL assert sw_start for exactly one cycle, only if sw_ready=1, then go to ACK; if sw_ready=0, SHALL remain in ISSUE with sw_start=0.
REQ-014 SHALL hold sw_data_a/sw_data_b stable from the ISSUE cycle until the next job is accepted.
REQ-015 ACK: SHALL wait for sw_ready=0 (responder accepted the job), then go to WAIT.
REQ-016 WAIT: SHALL wait for sw_ready=1, then go to DONE.
REQ-017 DONE: if out_valid=0, or out_valid and out_ready are both 1 in the same cycle, SHALL load sw_max_out into out_result, set out_valid, increment jobs_done, and go to IDLE; otherwise SHALL stall in DONE.
REQ-018 SHALL clear out_valid when out_valid and out_ready are both 1 and DONE is not loading in that cycle.
REQ-019 SHALL keep out_result stable while out_valid=1 and out_ready=0.
REQ-020 SHALL let jobs_done wrap from 2^CNT_W-1 to 0.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 Latency from the accept cycle to out_valid SHALL be 4 cycles plus the responder's ready-low period.

Reset
REQ-023 While resetb=0 at a clk edge, SHALL set: state=IDLE, sw_start=0, sw_data_a=0, sw_data_b=0, out_valid=0, out_result=0, jobs_done=0, error=0.
REQ-024 Reset mid-job SHALL drop the in-flight job and leave no pending result; the responder's late completion SHALL be ignored, because IDLE does not sample sw_max_out.

Configuration
REQ-025 With SW_ISSUER_TIMEOUT_EN defined, SHALL count cycles spent in ACK+WAIT; on reaching TIMEOUT_CYCLES, SHALL set error=1 (sticky until reset), drop the job without incrementing jobs_done, and return to IDLE.
REQ-026 Without SW_ISSUER_TIMEOUT_EN, SHALL wait indefinitely and tie error to 0.

Structure
REQ-027 The shared package SHALL hold the state enum type, the DATA_W/RES_W defaults, and the default TIMEOUT_CYCLES.
REQ-028 The output holding register and its valid/ready logic SHALL be a sub-module named sw_result_reg.

Verification
REQ-029 Single job: in_data=512'h1, in_weight=512'h2; responder holds ready low 12 cycles and returns max_out=256'hABCD -> exactly one sw_start pulse, out_result=256'hABCD, jobs_done=1.
REQ-030 Backpressure: out_ready=0, two jobs offered -> second result stalls in DONE, first result stays stable; out_ready=1 -> both delivered in order.
REQ-031 Issue while sw_ready=0 -> sw_start stays 0 until sw_ready=1, then pulses once.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=64): responder never raises ready -> error=1 64 cycles after entering ACK, state IDLE, jobs_done unchanged, out_valid=0.
REQ-033 Reset in WAIT -> after reset: out_valid=0, jobs_done=0, in_ready=1; a later sw_ready rise produces no result.
REQ-034 Counter wrap: CNT_W=4, run 16 jobs -> jobs_done reads 0.

Source files
------------

// File: rtl/sw_job_issuer_pkg.sv
// Shared types and default sizing for the sw_job_issuer slice.
package sw_job_issuer_pkg;

  localparam int unsigned DATA_W_DEF         = 512;
  localparam int unsigned RES_W_DEF          = 256;
  localparam int unsigned CNT_W_DEF          = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  // Issuer control states, in job order.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACK   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sw_job_issuer_if.sv
// sw_bus: start/ready handshake between a job initiator and a compute responder.
interface sw_job_issuer_if
  import sw_job_issuer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RES_W  = RES_W_DEF
) ();

  logic              sw_start;
  logic [DATA_W-1:0] sw_data_a;
  logic [DATA_W-1:0] sw_data_b;
  logic              sw_ready;
  logic [RES_W-1:0]  sw_max_out;

  modport master (
    output sw_start,
    output sw_data_a,
    output sw_data_b,
    input  sw_ready,
    input  sw_max_out
  );

  modport slave (
    input  sw_start,
    input  sw_data_a,
    input  sw_data_b,
    output sw_ready,
    output sw_max_out
  );

endinterface

// File: rtl/sw_job_issuer_result_reg.sv
// sw_result_reg: single-entry output holding register with valid/ready.
// A load always wins; otherwise a valid&ready handshake empties the entry.
module sw_result_reg
  import sw_job_issuer_pkg::*;
#(
  parameter int unsigned RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load_i,
  input  logic [RES_W-1:0] data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [RES_W-1:0] out_result_o
);

  logic             valid_q, valid_d;
  logic [RES_W-1:0] result_q, result_d;

  // Next entry: load new result, or drop the current one once consumed.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    if (load_i) begin
      valid_d  = 1'b1;
      result_d = data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d  = 1'b0;
    end
  end

  // Holding register; result only changes on a load, so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_result_o = result_q;

endmodule

// File: rtl/sw_job_issuer.sv
// sw_job_issuer: accepts one job at a time, issues it over sw_bus, waits for the
// responder to take and finish it, and parks the result in sw_result_reg.
// Optional watchdog on the ACK+WAIT phase: define SW_ISSUER_TIMEOUT_EN.
module sw_job_issuer
  import sw_job_issuer_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned RES_W          = RES_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  sw_job_issuer_if.master   sw_bus,
  output logic              busy,
  output logic [CNT_W-1:0]  jobs_done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_a_q, data_b_q;
  logic [CNT_W-1:0]  jobs_q;
  logic              accept;
  logic              load;
  logic              timeout_hit;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef SW_ISSUER_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             error_q, error_d;
  logic             pending;

  assign pending     = (state_q == ST_ACK) || (state_q == ST_WAIT);
  assign timeout_hit = pending && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Cycle count restarts every time the job leaves ACK/WAIT; error is sticky.
  always_comb begin
    timer_d = pending ? timer_q + 1'b1 : '0;
    error_d = error_q | timeout_hit;
  end

  // Watchdog state.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  // Without the watchdog the issuer waits on the responder forever.
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign error              = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (!resetb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: one job walks IDLE -> ISSUE -> ACK -> WAIT -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)                 state_d = ST_ISSUE;
      ST_ISSUE: if (sw_bus.sw_ready)          state_d = ST_ACK;
      ST_ACK: begin
        if (timeout_hit)                      state_d = ST_IDLE;
        else if (!sw_bus.sw_ready)            state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timeout_hit)                      state_d = ST_IDLE;
        else if (sw_bus.sw_ready)             state_d = ST_DONE;
      end
      ST_DONE:  if (!out_valid || out_ready)  state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Outputs: start only pulses while ISSUE sees an idle responder.
  always_comb begin
    in_ready        = 1'b0;
    busy            = 1'b1;
    sw_bus.sw_start = 1'b0;
    accept          = 1'b0;
    load            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
      end
      ST_ISSUE: sw_bus.sw_start = sw_bus.sw_ready;
      ST_DONE:  load = !out_valid || out_ready;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Operands are captured on accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else if (accept) begin
      data_a_q <= in_data;
      data_b_q <= in_weight;
    end
  end

  // Completed-job counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!resetb)   jobs_q <= '0;
    else if (load) jobs_q <= jobs_q + 1'b1;
  end

  assign sw_bus.sw_data_a = data_a_q;
  assign sw_bus.sw_data_b = data_b_q;
  assign jobs_done        = jobs_q;

  sw_result_reg #(
    .RES_W (RES_W)
  ) u_result_reg (
    .clk          (clk),
    .resetb       (resetb),
    .load_i       (load),
    .data_i       (sw_bus.sw_max_out),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_result_o (out_result)
  );

endmodule
